// File: rtl/bmp_pkg.sv
// bmp_pkg: shared BMP header constants, FSM state type and header byte generator.
package bmp_pkg;
  localparam int BMP_HEADER_SIZE = 138;
  localparam int BYTES_PER_PIXEL = 3;
  typedef enum logic [1:0] {IDLE, HEADER, PIXEL, DONE} state_t;
  function automatic logic [7:0] hdr_byte(input int idx, input int width, input int height,
                                          input int hsize = BMP_HEADER_SIZE);
    int img;
    int base;
    logic [31:0] field;
    logic [31:0] sh;
    img = width * height * BYTES_PER_PIXEL;
    base = idx;
    field = '0;
    // Each multi-byte field is little-endian; base is the field's first byte offset.
    if (idx < 2) field = (idx == 0) ? 32'h42 : 32'h4D;
    else if (idx < 6) begin base = 2; field = 32'(hsize + img); end
    else if (idx >= 10 && idx < 14) begin base = 10; field = 32'(hsize); end
    else if (idx >= 14 && idx < 18) begin base = 14; field = 32'd124; end
    else if (idx >= 18 && idx < 22) begin base = 18; field = 32'(width); end
    else if (idx >= 22 && idx < 26) begin base = 22; field = 32'(height); end
    else if (idx >= 26 && idx < 28) begin base = 26; field = 32'd1; end
    else if (idx >= 28 && idx < 30) begin base = 28; field = 32'd24; end
    else if (idx >= 34 && idx < 38) begin base = 34; field = 32'(img); end
    sh = field >> (8 * (idx - base));
    return sh[7:0];
  endfunction
endpackage

// File: rtl/bmp_stream_writer.sv
// bmp_stream_writer: streams a 24-bit BMP file (header then B,G,R-replicated gray pixels)
// from an upstream byte FIFO into a downstream byte FIFO with zero added latency.
module bmp_stream_writer #(
  parameter int WIDTH = 1280,
  parameter int HEIGHT = 720,
  parameter int BMP_HEADER_SIZE = bmp_pkg::BMP_HEADER_SIZE
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       start,
  input  logic       in_empty,
  input  logic [7:0] in_dout,
  output logic       in_rd_en,
  input  logic       out_full,
  output logic       out_wr_en,
  output logic [7:0] out_din,
  output logic       busy,
  output logic       done
);
  import bmp_pkg::*;
  localparam int NPIX = WIDTH * HEIGHT;
  localparam int PW = $clog2(NPIX + 1);
  localparam int BW = $clog2(BMP_HEADER_SIZE);
  if ((WIDTH * BYTES_PER_PIXEL) % 4 != 0) begin : g_pad_check
    $error("bmp_stream_writer: WIDTH*3 must be a multiple of 4 (row padding unsupported)");
  end
  state_t state, state_next;
  logic [BW-1:0] byte_idx;
  logic [PW-1:0] pix_cnt;
  logic [1:0] sub;
  logic last_hdr, last_sub, last_pix;
  assign last_hdr = byte_idx == BW'(BMP_HEADER_SIZE - 1);
  assign last_sub = sub == 2'(BYTES_PER_PIXEL - 1);
  assign last_pix = pix_cnt == PW'(NPIX - 1);
  // Outputs are gated by reset so an aborted frame never writes or pops in the reset cycle.
  always_comb begin
    state_next = state;
    out_din = 8'h00;
    out_wr_en = 1'b0;
    in_rd_en = 1'b0;
    busy = 1'b0;
    done = 1'b0;
    if (!reset)
      case (state)
        IDLE: state_next = start ? HEADER : IDLE;
        HEADER: begin
          busy = 1'b1;
          out_din = hdr_byte(int'(byte_idx), WIDTH, HEIGHT, BMP_HEADER_SIZE);
          out_wr_en = !out_full;
          if (out_wr_en && last_hdr) state_next = PIXEL;
        end
        PIXEL: begin
          busy = 1'b1;
          out_din = in_dout;
          out_wr_en = !out_full && !in_empty;
          in_rd_en = out_wr_en && last_sub;
          if (in_rd_en && last_pix) state_next = DONE;
        end
        DONE: begin
          done = 1'b1;
          state_next = start ? HEADER : DONE;
        end
        default: state_next = IDLE;
      endcase
  end
  always_ff @(posedge clock) begin
    if (reset) begin
      state <= IDLE;
      byte_idx <= '0;
      pix_cnt <= '0;
      sub <= '0;
    end else begin
      state <= state_next;
      if (start && (state == IDLE || state == DONE)) begin
        byte_idx <= '0;
        pix_cnt <= '0;
        sub <= '0;
      end else begin
        if (state == HEADER && out_wr_en && !last_hdr) byte_idx <= byte_idx + 1'b1;
        if (state == PIXEL && out_wr_en) sub <= last_sub ? 2'd0 : sub + 2'd1;
        if (in_rd_en) pix_cnt <= pix_cnt + 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_bmp_stream_writer.sv
// tb_bmp_stream_writer: scoreboard bench for a 4x2 frame (162 bytes) with stalls, resets and restarts.
module tb_bmp_stream_writer;
  localparam int W = 4;
  localparam int H = 2;
  localparam int HS = 138;
  localparam int NPIX = W * H;
  localparam int TOTAL = HS + NPIX * 3;
  logic clock = 1'b0;
  logic reset, start, in_empty, out_full;
  logic [7:0] in_dout;
  logic in_rd_en, out_wr_en, busy, done;
  logic [7:0] out_din;
  int errors = 0;
  int checks = 0;
  logic [7:0] hdr_ref [0:HS-1];
  logic [7:0] exp_q[$];
  logic [7:0] src_q[$];
  logic [7:0] wr_log[$];
  logic [7:0] e;
  int pop_total = 0;
  int applied = 0;
  int pop_base = 0;
  bit hold_full = 0;
  bit hold_empty = 0;
  bit rand_full = 0;
  bmp_stream_writer #(.WIDTH(W), .HEIGHT(H), .BMP_HEADER_SIZE(HS)) dut (
    .clock(clock), .reset(reset), .start(start), .in_empty(in_empty), .in_dout(in_dout),
    .in_rd_en(in_rd_en), .out_full(out_full), .out_wr_en(out_wr_en), .out_din(out_din),
    .busy(busy), .done(done)
  );
  always #5 clock = ~clock;
  // Monitor: protocol checks and scoreboard pop on every downstream write.
  always @(negedge clock) begin
    if (out_full === 1'b1) begin
      checks++;
      if (out_wr_en !== 1'b0) begin errors++; $display("FAIL wr_while_full: out_wr_en=%b required 0", out_wr_en); end
    end
    if (in_empty === 1'b1) begin
      checks++;
      if (in_rd_en !== 1'b0) begin errors++; $display("FAIL rd_while_empty: in_rd_en=%b required 0", in_rd_en); end
    end
    if (out_wr_en === 1'b1) begin
      checks++;
      wr_log.push_back(out_din);
      if (exp_q.size() == 0) begin
        errors++; $display("FAIL extra_byte: got %02h with nothing expected", out_din);
      end else begin
        e = exp_q.pop_front();
        if (out_din !== e) begin errors++; $display("FAIL byte[%0d]: got %02h required %02h", wr_log.size() - 1, out_din, e); end
      end
    end
    if (in_rd_en === 1'b1) pop_total++;
  end
  task automatic step();
    @(posedge clock);
    #1;
    while (applied < pop_total) begin
      if (src_q.size() > 0) void'(src_q.pop_front());
      applied++;
    end
    out_full = hold_full || (rand_full && $urandom_range(0, 3) == 0);
    in_empty = hold_empty || src_q.size() == 0;
    in_dout = (src_q.size() > 0) ? src_q[0] : 8'h00;
  endtask
  task automatic init_ref();
    for (int i = 0; i < HS; i++) hdr_ref[i] = 8'h00;
    hdr_ref[0] = 8'h42; hdr_ref[1] = 8'h4D;
    hdr_ref[2] = 8'hA2;
    hdr_ref[10] = 8'h8A;
    hdr_ref[14] = 8'h7C;
    hdr_ref[18] = 8'h04;
    hdr_ref[22] = 8'h02;
    hdr_ref[26] = 8'h01;
    hdr_ref[28] = 8'h18;
    hdr_ref[34] = 8'h18;
  endtask
  task automatic load_frame(input logic [7:0] p0, input logic [7:0] stp);
    logic [7:0] p;
    wr_log.delete();
    pop_base = pop_total;
    for (int i = 0; i < HS; i++) exp_q.push_back(hdr_ref[i]);
    for (int i = 0; i < NPIX; i++) begin
      p = p0 + 8'(i) * stp;
      src_q.push_back(p);
      repeat (3) exp_q.push_back(p);
    end
  endtask
  task automatic pulse_start();
    start = 1'b1;
    step();
    start = 1'b0;
  endtask
  task automatic run_until_done(input int budget, output bit ok);
    ok = 0;
    for (int i = 0; i < budget; i++) begin
      step();
      if (done === 1'b1) begin ok = 1; break; end
    end
  endtask
  task automatic test_reset();
    reset = 1'b1; start = 1'b0; out_full = 1'b0; in_empty = 1'b1; in_dout = 8'h00;
    repeat (3) step();
    @(negedge clock);
    checks++; if (in_rd_en !== 1'b0) begin errors++; $display("FAIL reset_rd: got %b required 0", in_rd_en); end
    checks++; if (out_wr_en !== 1'b0) begin errors++; $display("FAIL reset_wr: got %b required 0", out_wr_en); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b required 0", busy); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b required 0", done); end
    checks++; if (out_din !== 8'h00) begin errors++; $display("FAIL reset_din: got %02h required 00", out_din); end
    reset = 1'b0;
    step();
  endtask
  task automatic test_full_frame();
    bit ok;
    load_frame(8'h10, 8'h10);
    step();
    pulse_start();
    run_until_done(400, ok);
    checks++; if (!ok) begin errors++; $display("FAIL frame_done: done never rose in budget"); end
    checks++; if (wr_log.size() != TOTAL) begin errors++; $display("FAIL frame_len: got %0d required %0d", wr_log.size(), TOTAL); end
    checks++; if (pop_total - pop_base != NPIX) begin errors++; $display("FAIL frame_pops: got %0d required %0d", pop_total - pop_base, NPIX); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL frame_busy: got %b required 0", busy); end
    if (wr_log.size() >= TOTAL) begin
      checks++; if ({wr_log[0], wr_log[1], wr_log[2], wr_log[3], wr_log[4], wr_log[5]} !== 48'h424DA2000000) begin
        errors++; $display("FAIL hdr_0_5: got %02h %02h %02h %02h %02h %02h required 42 4D A2 00 00 00", wr_log[0], wr_log[1], wr_log[2], wr_log[3], wr_log[4], wr_log[5]); end
      checks++; if ({wr_log[34], wr_log[35], wr_log[36], wr_log[37]} !== 32'h18000000) begin
        errors++; $display("FAIL hdr_34_37: got %02h %02h %02h %02h required 18 00 00 00", wr_log[34], wr_log[35], wr_log[36], wr_log[37]); end
      checks++; if ({wr_log[138], wr_log[139], wr_log[140], wr_log[141], wr_log[142], wr_log[143]} !== 48'h101010202020) begin
        errors++; $display("FAIL pix_copies: got %02h %02h %02h %02h %02h %02h required 10 10 10 20 20 20", wr_log[138], wr_log[139], wr_log[140], wr_log[141], wr_log[142], wr_log[143]); end
    end
    step();
    checks++; if (done !== 1'b1) begin errors++; $display("FAIL done_hold: got %b required 1", done); end
  endtask
  task automatic test_header_stall();
    bit ok;
    int i;
    load_frame(8'h31, 8'h07);
    pulse_start();
    i = 0;
    while (wr_log.size() < 20 && i < 100) begin step(); i++; end
    hold_full = 1; out_full = 1'b1;
    repeat (5) step();
    checks++; if (wr_log.size() != 20) begin errors++; $display("FAIL hdr_stall_len: got %0d required 20", wr_log.size()); end
    hold_full = 0; out_full = 1'b0;
    run_until_done(400, ok);
    checks++; if (!ok || wr_log.size() != TOTAL) begin errors++; $display("FAIL hdr_stall_frame: done=%b len=%0d required 1/%0d", ok, wr_log.size(), TOTAL); end
    checks++; if (wr_log.size() > 21 && {wr_log[19], wr_log[20], wr_log[21]} !== 24'h000000) begin
      errors++; $display("FAIL hdr_stall_b20: got %02h %02h %02h required 00 00 00", wr_log[19], wr_log[20], wr_log[21]); end
  endtask
  task automatic test_empty_stall();
    bit ok;
    int i, w, p;
    load_frame(8'hA0, 8'h03);
    pulse_start();
    i = 0;
    while (wr_log.size() < HS + 4 && i < 300) begin step(); i++; end
    hold_empty = 1; in_empty = 1'b1;
    w = wr_log.size(); p = pop_total;
    repeat (4) step();
    checks++; if (wr_log.size() != w) begin errors++; $display("FAIL empty_pause: wrote %0d bytes required 0", wr_log.size() - w); end
    checks++; if (pop_total != p) begin errors++; $display("FAIL empty_early_pop: popped %0d required 0", pop_total - p); end
    hold_empty = 0; in_empty = src_q.size() == 0;
    run_until_done(400, ok);
    checks++; if (!ok || wr_log.size() != TOTAL) begin errors++; $display("FAIL empty_frame: done=%b len=%0d required 1/%0d", ok, wr_log.size(), TOTAL); end
    checks++; if (pop_total - pop_base != NPIX) begin errors++; $display("FAIL empty_pops: got %0d required %0d", pop_total - pop_base, NPIX); end
  endtask
  task automatic test_reset_mid();
    bit ok;
    int i;
    load_frame(8'h55, 8'h11);
    pulse_start();
    i = 0;
    while (pop_total - pop_base < 3 && i < 300) begin step(); i++; end
    reset = 1'b1;
    @(negedge clock);
    checks++; if ({in_rd_en, out_wr_en, busy, done} !== 4'b0000 || out_din !== 8'h00) begin
      errors++; $display("FAIL rst_cycle: rd=%b wr=%b busy=%b done=%b din=%02h required all 0", in_rd_en, out_wr_en, busy, done, out_din); end
    step();
    reset = 1'b0;
    @(negedge clock);
    checks++; if ({in_rd_en, out_wr_en, busy, done} !== 4'b0000 || out_din !== 8'h00) begin
      errors++; $display("FAIL rst_next: rd=%b wr=%b busy=%b done=%b din=%02h required all 0", in_rd_en, out_wr_en, busy, done, out_din); end
    exp_q.delete(); src_q.delete(); applied = pop_total;
    step();
    load_frame(8'h02, 8'h21);
    pulse_start();
    run_until_done(400, ok);
    checks++; if (!ok || wr_log.size() != TOTAL) begin errors++; $display("FAIL rst_frame: done=%b len=%0d required 1/%0d", ok, wr_log.size(), TOTAL); end
    checks++; if (wr_log.size() == 0 || wr_log[0] !== 8'h42) begin errors++; $display("FAIL rst_first_byte: got %02h required 42", (wr_log.size() > 0) ? wr_log[0] : 8'hxx); end
  endtask
  task automatic test_start_in_header();
    bit ok;
    int i;
    load_frame(8'hC3, 8'h05);
    pulse_start();
    i = 0;
    while (wr_log.size() < 30 && i < 100) begin step(); i++; end
    pulse_start();
    run_until_done(400, ok);
    checks++; if (!ok || wr_log.size() != TOTAL) begin errors++; $display("FAIL hdr_start_frame: done=%b len=%0d required 1/%0d", ok, wr_log.size(), TOTAL); end
    checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL hdr_start_left: %0d bytes left required 0", exp_q.size()); end
  endtask
  task automatic test_back_to_back();
    bit ok;
    load_frame(8'h09, 8'h1D);
    pulse_start();
    checks++; if (busy !== 1'b1 || done !== 1'b0) begin errors++; $display("FAIL b2b_restart: busy=%b done=%b required 1/0", busy, done); end
    rand_full = 1;
    run_until_done(1000, ok);
    rand_full = 0;
    checks++; if (!ok || wr_log.size() != TOTAL) begin errors++; $display("FAIL b2b_frame: done=%b len=%0d required 1/%0d", ok, wr_log.size(), TOTAL); end
    checks++; if (pop_total - pop_base != NPIX) begin errors++; $display("FAIL b2b_pops: got %0d required %0d", pop_total - pop_base, NPIX); end
  endtask
  initial begin
    init_ref();
    test_reset();
    test_full_frame();
    test_header_stall();
    test_empty_stall();
    test_reset_mid();
    test_start_in_header();
    test_back_to_back();
    repeat (3) step();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
